// File: rtl/en_burst_gen_if.sv
// ============================================================================
//  Module   : en_burst_gen_if
//  Brief    : Control/status bundle between a sequencer and en_burst_gen.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface en_burst_gen_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [CNT_W-1:0] bursts;
    logic             en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] burst_idx;

    modport master (
        output start, abort, on_len, off_len, bursts,
        input  en, busy, done, burst_idx
    );

    modport slave (
        input  start, abort, on_len, off_len, bursts,
        output en, busy, done, burst_idx
    );
endinterface

`default_nettype wire

// File: rtl/en_burst_gen.sv
// ============================================================================
//  Module   : en_burst_gen
//  Brief    : Programmable ON/OFF enable-burst generator with progress/done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module en_burst_gen #(
    parameter int CNT_W = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    en_burst_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_on_len,    w_on_len_nxt;
    logic [CNT_W-1:0] r_off_len,   w_off_len_nxt;
    logic [CNT_W-1:0] r_bursts,    w_bursts_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [CNT_W-1:0] r_burst_idx, w_burst_idx_nxt;
    logic             r_en;
    logic             r_busy;
    logic             r_done;

    // r_cnt holds the cycles remaining in the current phase after this one
    always_comb begin
        w_state_nxt     = r_state;
        w_on_len_nxt    = r_on_len;
        w_off_len_nxt   = r_off_len;
        w_bursts_nxt    = r_bursts;
        w_cnt_nxt       = r_cnt;
        w_burst_idx_nxt = r_burst_idx;

        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_on_len_nxt    = bus.on_len;
                    w_off_len_nxt   = bus.off_len;
                    w_bursts_nxt    = bus.bursts;
                    w_burst_idx_nxt = '0;
                    if (bus.on_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = bus.on_len - c_one;
                    end
                end
            end

            S_ON: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_burst_idx_nxt = r_burst_idx + c_one;
                    if ((r_bursts != '0) && (w_burst_idx_nxt == r_bursts)) begin
                        w_state_nxt = S_DONE;
                    end else if (r_off_len == '0) begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = r_on_len - c_one;
                    end else begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = r_off_len - c_one;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end

            S_OFF: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = r_on_len - c_one;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_on_len    <= '0;
            r_off_len   <= '0;
            r_bursts    <= '0;
            r_cnt       <= '0;
            r_burst_idx <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_on_len    <= w_on_len_nxt;
            r_off_len   <= w_off_len_nxt;
            r_bursts    <= w_bursts_nxt;
            r_cnt       <= w_cnt_nxt;
            r_burst_idx <= w_burst_idx_nxt;
            r_en        <= (w_state_nxt == S_ON);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.en        = r_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.burst_idx = r_burst_idx;

endmodule

`default_nettype wire

// File: tb/tb_en_burst_gen.sv
// ============================================================================
//  Module   : tb_en_burst_gen
//  Brief    : Directed self-checking bench for en_burst_gen.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_en_burst_gen;

    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int done_cnt = 0;
    int base_en;
    int base_done;
    logic [7:0] pat;

    en_burst_gen_if #(.CNT_W(CNT_W)) bus ();

    en_burst_gen #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream counter: one increment per enabled edge
    always @(posedge clk) begin
        if (bus.en === 1'b1) en_cnt <= en_cnt + 1;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.on_len  = '0;
        bus.off_len = '0;
        bus.bursts  = '0;

        // Reset state
        #3;
        chk("rst_en",   {31'd0, bus.en},   32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_idx",  {16'd0, bus.burst_idx}, 32'd0);
        #9 reset = 1'b1;
        tick();

        // Basic pattern: on=3 off=2 bursts=2
        base_en = en_cnt;
        bus.on_len = 16'd3; bus.off_len = 16'd2; bus.bursts = 16'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("basic_busy", {31'd0, bus.busy}, 32'd1);
        pat = 8'b1110_0111;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("basic_en%0d", i), {31'd0, bus.en}, {31'd0, pat[7-i]});
            chk($sformatf("basic_nodone%0d", i), {31'd0, bus.done}, 32'd0);
            tick();
        end
        chk("basic_done", {31'd0, bus.done}, 32'd1);
        chk("basic_en_off", {31'd0, bus.en}, 32'd0);
        chk("basic_idx", {16'd0, bus.burst_idx}, 32'd2);
        chk("basic_count", en_cnt - base_en, 32'd6);
        tick();
        chk("basic_done_end", {31'd0, bus.done}, 32'd0);
        chk("basic_busy_end", {31'd0, bus.busy}, 32'd0);

        // Zero length
        base_en = en_cnt;
        bus.on_len = 16'd0; bus.off_len = 16'd0; bus.bursts = 16'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("zero_done", {31'd0, bus.done}, 32'd1);
        chk("zero_busy", {31'd0, bus.busy}, 32'd1);
        chk("zero_en",   {31'd0, bus.en},   32'd0);
        tick();
        chk("zero_done_end", {31'd0, bus.done}, 32'd0);
        chk("zero_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("zero_count", en_cnt - base_en, 32'd0);
        chk("zero_idx", {16'd0, bus.burst_idx}, 32'd0);

        // Gapless continuous run, aborted after 10 enabled cycles
        base_en   = en_cnt;
        base_done = done_cnt;
        bus.on_len = 16'd4; bus.off_len = 16'd0; bus.bursts = 16'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("cont_en%0d", i), {31'd0, bus.en}, 32'd1);
            if (i == 4) chk("cont_idx1", {16'd0, bus.burst_idx}, 32'd1);
            if (i == 8) chk("cont_idx2", {16'd0, bus.burst_idx}, 32'd2);
            if (i == 9) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        chk("abort_en",    {31'd0, bus.en},   32'd0);
        chk("abort_busy",  {31'd0, bus.busy}, 32'd0);
        chk("abort_done",  {31'd0, bus.done}, 32'd0);
        chk("abort_count", en_cnt - base_en, 32'd10);
        chk("abort_idx",   {16'd0, bus.burst_idx}, 32'd2);
        tick();
        chk("abort_nodone", done_cnt - base_done, 32'd0);

        // Busy protection: restart during ON is ignored
        base_en   = en_cnt;
        base_done = done_cnt;
        bus.on_len = 16'd5; bus.off_len = 16'd1; bus.bursts = 16'd1; bus.start = 1'b1;
        tick();
        bus.on_len = 16'd1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy_en%0d", i), {31'd0, bus.en}, 32'd1);
            tick();
        end
        chk("busy_done", {31'd0, bus.done}, 32'd1);
        chk("busy_en_off", {31'd0, bus.en}, 32'd0);
        tick();
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
        chk("busy_count", en_cnt - base_en, 32'd5);
        chk("busy_one_done", done_cnt - base_done, 32'd1);
        // Back-to-back start in the first IDLE cycle
        bus.on_len = 16'd2; bus.off_len = 16'd0; bus.bursts = 16'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_en",   {31'd0, bus.en},   32'd1);
        tick();
        tick();
        chk("b2b_done", {31'd0, bus.done}, 32'd1);
        chk("b2b_idx",  {16'd0, bus.burst_idx}, 32'd1);
        tick();

        // Asynchronous reset during OFF
        bus.on_len = 16'd2; bus.off_len = 16'd3; bus.bursts = 16'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("off_en",   {31'd0, bus.en},   32'd0);
        chk("off_busy", {31'd0, bus.busy}, 32'd1);
        chk("off_idx",  {16'd0, bus.burst_idx}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_en",   {31'd0, bus.en},   32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_idx",  {16'd0, bus.burst_idx}, 32'd0);
        #1 reset = 1'b1;
        base_en = en_cnt;
        tick();
        tick();
        tick();
        tick();
        chk("post_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("post_rst_count", en_cnt - base_en, 32'd0);

        // Simultaneous start and abort in IDLE
        bus.on_len = 16'd3; bus.off_len = 16'd1; bus.bursts = 16'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("sa_busy", {31'd0, bus.busy}, 32'd0);
        chk("sa_en",   {31'd0, bus.en},   32'd0);
        tick();
        chk("sa_busy2", {31'd0, bus.busy}, 32'd0);
        chk("sa_en2",   {31'd0, bus.en},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/en_burst_gen.md
# en_burst_gen

Programmable enable-pattern generator that drives the `en` input of the up-counter stage directly upstream. After a start pulse it emits a configurable number of enable bursts (ON cycles separated by OFF gaps), reports progress, and pulses `done` on completion. The exact number of enabled cycles is deterministic, so the downstream `count_out` can be checked against `on_len * bursts`.

## Interface
- `CNT_W`, 16, width of the length/burst fields and of `burst_idx`.

- `clk`  in  1  rising-edge clock shared with the counter.
- `reset`  in  1  asynchronous reset, active-low (0 = reset asserted).
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `abort`  in  1  terminate the current sequence; sampled every cycle.
- `on_len`  in  CNT_W  enabled cycles per burst; latched on accepted `start`.
- `off_len`  in  CNT_W  gap cycles between bursts; latched on accepted `start`.
- `bursts`  in  CNT_W  number of bursts; 0 = run until `abort`; latched on accepted `start`.
- `en`  out  1  registered enable to the counter.
- `busy`  out  1  high from the accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `burst_idx`  out  CNT_W  number of completed bursts in the current sequence.

## Operation
- States: IDLE, ON, OFF, DONE. All outputs are registered.
- Reset (`reset`=0, any time): state IDLE; `en`=0, `busy`=0, `done`=0, `burst_idx`=0; internal counters cleared. Takes effect immediately, without waiting for a clock edge.
- IDLE: with `start`=1 and `abort`=0, latch `on_len`, `off_len` and `bursts`, then:
  - clear `burst_idx`;
  - if `on_len`=0, go to DONE;
  - otherwise go to ON.
  - `start` with `abort`=1 in the same cycle is ignored.
- ON: `en`=1 for exactly `on_len` consecutive cycles. At the last ON cycle, `burst_idx` increments. Then:
  - if `bursts`≠0 and this was burst number `bursts`, go to DONE;
  - else if `off_len`=0, go directly to ON; `en` stays high with no gap;
  - else go to OFF.
- OFF: `en`=0 for exactly `off_len` cycles, then go to ON. No trailing OFF follows the final burst.
- DONE: `done`=1 and `en`=0 for one cycle, then IDLE. `busy` is high during DONE.
- `abort`=1 in ON, OFF or DONE: next state IDLE; `en`=0 and `busy`=0 from the next cycle; `done` is not pulsed; `burst_idx` holds its value until the next accepted `start`.
- `start` while `busy`=1 is ignored. Input changes after latching have no effect on a running sequence.
- `bursts`=0: ON/OFF alternation repeats until `abort`. `burst_idx` wraps modulo 2^CNT_W.
- Internal down-counters are CNT_W bits. The maximum values (2^CNT_W−1) for `on_len`, `off_len` and `bursts` must be honoured exactly.

## Timing
- `start` sampled high at edge N:
  - `busy`=1 and `en`=1 from edge N (visible in cycle N+1);
  - the first enabled counter increment occurs at edge N+1.
- `en` high cycles per sequence = `on_len` × `bursts`.
- Latency for `on_len`>0, `bursts`>0:
  - `done` rises at edge N + `bursts`·`on_len` + (`bursts`−1)·`off_len`;
  - `done` lasts 1 cycle;
  - `busy` falls 1 cycle after `done` rises.
- `on_len`=0: `done` rises at edge N, `en` never asserts, `busy` is high for 1 cycle.
- `abort` sampled at edge M: `en`=0 and `busy`=0 after edge M. The counter sees no increment at edge M+1.
- Back-to-back: a `start` in the first IDLE cycle after DONE is accepted. Minimum idle gap between sequences is 1 cycle.
- Reset deassertion is asynchronous. The first `start` is accepted at the first rising edge with `reset`=1.

## Test plan
- Basic pattern: `on_len`=3, `off_len`=2, `bursts`=2. Expect:
  - `en` sequence 1,1,1,0,0,1,1,1, then `done` for 1 cycle;
  - `burst_idx`=2;
  - counter `count_out` advances by exactly 6.
- Zero length: `on_len`=0, `bursts`=5. Expect `done` 1 cycle after `start`, `en` never high, counter unchanged.
- Gapless and continuous: `on_len`=4, `off_len`=0, `bursts`=0.
  - Expect `en` held continuously high and `burst_idx` incrementing every 4 cycles.
  - Assert `abort` after 10 enabled cycles: expect `en`=0 next cycle, no `done`, counter advanced by exactly 10.
- Busy protection: `on_len`=5, `off_len`=1, `bursts`=1. Pulse `start` again with `on_len`=1 during ON.
  - Expect exactly 5 `en` cycles and a single `done`.
  - Then a new `start` accepted in the first cycle after return to IDLE.
- Reset mid-operation: drive `reset`=0 between clock edges during OFF of a `bursts`=3 run.
  - Expect `en`, `busy`, `done` and `burst_idx` at 0 immediately.
  - After release, no `en` until a fresh `start`.
- Simultaneous `start` and `abort` in IDLE: expect `busy` to stay 0 and `en` to stay 0.
